// File: rtl/tap_controller.sv
// ----------------------------------------------------------------------------
// tap_controller
//
// IEEE 1149.1-style TAP controller sequencing the boundary-scan register that
// wraps the instruction memory. Decodes tms_i into the 16-state TAP machine,
// holds a 4-bit instruction register (shift stage + active register), owns the
// BYPASS and (optionally) IDCODE data registers, drives the boundary-chain
// controls and muxes the selected register onto tdo_o.
//
// Build option:
//   TAP_IDCODE_EN  defined   -> IDCODE register present, reset instruction
//                               is IDCODE (0010).
//                  undefined -> no IDCODE register, 0010 decodes as BYPASS,
//                               reset instruction is BYPASS (1111).
//
// Parameters:
//   IDCODE_VALUE   IDCODE register contents (bit 0 must be 1).
//
// Ports:
//   tck_i       test clock; state on rising edge, TDO on falling edge
//   trst_i      asynchronous active-high reset
//   tms_i       test mode select
//   tdi_i       test data in (also the boundary chain's serial input)
//   bsr_tdo_i   serial output of the last boundary-scan cell
//   clockDR_o   boundary-chain clock enable (Capture-DR/Shift-DR, BSR selected)
//   shiftDR_o   high in Shift-DR
//   updateDR_o  high in Update-DR while the BSR is selected
//   mode_o      high while EXTEST is the active instruction
//   tdo_o       test data out (falling-edge registered)
//   tdo_en_o    TDO driver enable (falling-edge registered)
//   state_o     current TAP state code, for debug
// ----------------------------------------------------------------------------
module tap_controller #(
    parameter logic [31:0] IDCODE_VALUE = 32'h1000_0001
) (
    input  logic       tck_i,
    input  logic       trst_i,
    input  logic       tms_i,
    input  logic       tdi_i,
    input  logic       bsr_tdo_i,
    output logic       clockDR_o,
    output logic       shiftDR_o,
    output logic       updateDR_o,
    output logic       mode_o,
    output logic       tdo_o,
    output logic       tdo_en_o,
    output logic [3:0] state_o
);

    typedef enum logic [3:0] {
        TLR   = 4'h0,
        RTI   = 4'h1,
        SELDR = 4'h2,
        CAPDR = 4'h3,
        SHDR  = 4'h4,
        EX1DR = 4'h5,
        PDR   = 4'h6,
        EX2DR = 4'h7,
        UPDR  = 4'h8,
        SELIR = 4'h9,
        CAPIR = 4'hA,
        SHIR  = 4'hB,
        EX1IR = 4'hC,
        PIR   = 4'hD,
        EX2IR = 4'hE,
        UPIR  = 4'hF
    } tap_state_t;

    localparam logic [3:0] OP_EXTEST  = 4'b0000;
    localparam logic [3:0] OP_SAMPLE  = 4'b0001;
    localparam logic [3:0] OP_IDCODE  = 4'b0010;
    localparam logic [3:0] OP_BYPASS  = 4'b1111;
    localparam logic [3:0] IR_CAPTURE = 4'b0001;

`ifdef TAP_IDCODE_EN
    localparam logic [3:0] RESET_INSTR = OP_IDCODE;
`else
    localparam logic [3:0] RESET_INSTR = OP_BYPASS;
`endif

    // IEEE 1149.1 requires the IDCODE LSB to be 1 so it is distinguishable
    // from the 0 that BYPASS captures.
    if (IDCODE_VALUE[0] != 1'b1) begin : g_bad_idcode
        $error("tap_controller: IDCODE_VALUE bit 0 must be 1");
    end

    tap_state_t state;
    tap_state_t next_state;

    logic [3:0] ir_shift;
    logic [3:0] ir;
    logic       bypass;
    logic       sel_bsr;
    logic       sel_bypass;
    logic       dr_out;
`ifdef TAP_IDCODE_EN
    logic       sel_idcode;
    logic [31:0] idcode;
`endif

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge tck_i or posedge trst_i) begin
        if (trst_i) begin
            state <= TLR;
        end else begin
            state <= next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and Moore control decode
    // ------------------------------------------------------------------
    always_comb begin
        next_state = state;
        clockDR_o  = 1'b0;
        shiftDR_o  = 1'b0;
        updateDR_o = 1'b0;
        mode_o     = 1'b0;

        case (state)
            TLR:   next_state = tms_i ? TLR   : RTI;
            RTI:   next_state = tms_i ? SELDR : RTI;
            SELDR: next_state = tms_i ? SELIR : CAPDR;
            CAPDR: next_state = tms_i ? EX1DR : SHDR;
            SHDR:  next_state = tms_i ? EX1DR : SHDR;
            EX1DR: next_state = tms_i ? UPDR  : PDR;
            PDR:   next_state = tms_i ? EX2DR : PDR;
            EX2DR: next_state = tms_i ? UPDR  : SHDR;
            UPDR:  next_state = tms_i ? SELDR : RTI;
            SELIR: next_state = tms_i ? TLR   : CAPIR;
            CAPIR: next_state = tms_i ? EX1IR : SHIR;
            SHIR:  next_state = tms_i ? EX1IR : SHIR;
            EX1IR: next_state = tms_i ? UPIR  : PIR;
            PIR:   next_state = tms_i ? EX2IR : PIR;
            EX2IR: next_state = tms_i ? UPIR  : SHIR;
            UPIR:  next_state = tms_i ? SELDR : RTI;
            default: next_state = TLR;
        endcase

        clockDR_o  = sel_bsr && ((state == CAPDR) || (state == SHDR));
        shiftDR_o  = (state == SHDR);
        updateDR_o = sel_bsr && (state == UPDR);
        mode_o     = (ir == OP_EXTEST);
    end

    // ------------------------------------------------------------------
    // Instruction decode
    // ------------------------------------------------------------------
    always_comb begin
        sel_bsr    = 1'b0;
        sel_bypass = 1'b0;
`ifdef TAP_IDCODE_EN
        sel_idcode = 1'b0;
`endif
        case (ir)
            OP_EXTEST, OP_SAMPLE: sel_bsr = 1'b1;
`ifdef TAP_IDCODE_EN
            OP_IDCODE: sel_idcode = 1'b1;
`endif
            default: sel_bypass = 1'b1;
        endcase
    end

    // ------------------------------------------------------------------
    // Instruction register: shift stage and active register
    // ------------------------------------------------------------------
    always_ff @(posedge tck_i or posedge trst_i) begin
        if (trst_i) begin
            ir_shift <= IR_CAPTURE;
        end else if (state == CAPIR) begin
            ir_shift <= IR_CAPTURE;
        end else if (state == SHIR) begin
            ir_shift <= {tdi_i, ir_shift[3:1]};
        end
    end

    // Loading the reset instruction on the edge that enters TLR means the
    // active IR already holds it for the whole time the FSM sits in TLR.
    always_ff @(posedge tck_i or posedge trst_i) begin
        if (trst_i) begin
            ir <= RESET_INSTR;
        end else if (next_state == TLR) begin
            ir <= RESET_INSTR;
        end else if (state == UPIR) begin
            ir <= ir_shift;
        end
    end

    // ------------------------------------------------------------------
    // Internal data registers (capture/shift only while selected)
    // ------------------------------------------------------------------
    always_ff @(posedge tck_i or posedge trst_i) begin
        if (trst_i) begin
            bypass <= 1'b0;
        end else if (sel_bypass) begin
            if (state == CAPDR) begin
                bypass <= 1'b0;
            end else if (state == SHDR) begin
                bypass <= tdi_i;
            end
        end
    end

`ifdef TAP_IDCODE_EN
    always_ff @(posedge tck_i or posedge trst_i) begin
        if (trst_i) begin
            idcode <= IDCODE_VALUE;
        end else if (sel_idcode) begin
            if (state == CAPDR) begin
                idcode <= IDCODE_VALUE;
            end else if (state == SHDR) begin
                idcode <= {tdi_i, idcode[31:1]};
            end
        end
    end
`endif

    always_comb begin
        dr_out = bypass;
        if (sel_bsr) begin
            dr_out = bsr_tdo_i;
        end
`ifdef TAP_IDCODE_EN
        else if (sel_idcode) begin
            dr_out = idcode[0];
        end
`endif
    end

    // ------------------------------------------------------------------
    // TDO: registered on the falling edge so it is stable around the
    // next rising edge where the receiving device samples it.
    // ------------------------------------------------------------------
    always_ff @(negedge tck_i or posedge trst_i) begin
        if (trst_i) begin
            tdo_o    <= 1'b0;
            tdo_en_o <= 1'b0;
        end else if (state == SHIR) begin
            tdo_o    <= ir_shift[0];
            tdo_en_o <= 1'b1;
        end else if (state == SHDR) begin
            tdo_o    <= dr_out;
            tdo_en_o <= 1'b1;
        end else begin
            tdo_o    <= 1'b0;
            tdo_en_o <= 1'b0;
        end
    end

    assign state_o = state;

endmodule

// File: tb/tb_tap_controller.sv
// ----------------------------------------------------------------------------
// tb_tap_controller
//
// Self-checking bench for tap_controller. A behavioural model (transition
// table plus plain register arithmetic) predicts every control output after
// each rising edge and TDO/TDO-enable after each falling edge. Directed scans
// cover IDCODE, BYPASS, EXTEST, paused IR scans and mid-shift reset; a random
// phase drives TMS/TDI/BSR-TDO with occasional resets.
// ----------------------------------------------------------------------------
module tb_tap_controller;

    localparam logic [31:0] IDV = 32'h1000_0001;
`ifdef TAP_IDCODE_EN
    localparam logic [3:0] M_RST_IR = 4'b0010;
    localparam bit         M_HAS_ID = 1'b1;
`else
    localparam logic [3:0] M_RST_IR = 4'b1111;
    localparam bit         M_HAS_ID = 1'b0;
`endif

    logic       tck;
    logic       trst;
    logic       tms;
    logic       tdi;
    logic       bsr;
    logic       clock_dr;
    logic       shift_dr;
    logic       update_dr;
    logic       mode;
    logic       tdo;
    logic       tdo_en;
    logic [3:0] state;

    int n_cmp;
    int n_err;

    tap_controller #(.IDCODE_VALUE(IDV)) dut (
        .tck_i      (tck),
        .trst_i     (trst),
        .tms_i      (tms),
        .tdi_i      (tdi),
        .bsr_tdo_i  (bsr),
        .clockDR_o  (clock_dr),
        .shiftDR_o  (shift_dr),
        .updateDR_o (update_dr),
        .mode_o     (mode),
        .tdo_o      (tdo),
        .tdo_en_o   (tdo_en),
        .state_o    (state)
    );

    initial begin
        tck = 1'b0;
        forever #5 tck = ~tck;
    end

    // ---------------- reference model ----------------
    int nxt0[16] = '{1, 1, 3, 4, 4, 6, 6, 4, 1, 10, 11, 11, 13, 13, 11, 1};
    int nxt1[16] = '{0, 2, 9, 5, 5, 8, 7, 8, 2, 0, 12, 12, 15, 14, 15, 2};

    int          m_state;
    logic [3:0]  m_irs;
    logic [3:0]  m_ir;
    logic        m_byp;
    logic [31:0] m_id;

    // 0 = boundary chain, 1 = IDCODE, 2 = BYPASS
    function automatic int m_sel(input logic [3:0] op);
        if (op == 4'd0 || op == 4'd1) return 0;
        if (op == 4'd2 && M_HAS_ID) return 1;
        return 2;
    endfunction

    task automatic model_reset();
        m_state = 0;
        m_irs   = 4'b0001;
        m_ir    = M_RST_IR;
        m_byp   = 1'b0;
        m_id    = IDV;
    endtask

    task automatic model_edge(input logic t, input logic d);
        int old;
        old = m_state;
        m_state = t ? nxt1[old] : nxt0[old];
        if (old == 10) m_irs = 4'b0001;
        if (old == 11) m_irs = (m_irs >> 1) | (4'(d) << 3);
        if (old == 3 && m_sel(m_ir) == 2) m_byp = 1'b0;
        if (old == 3 && m_sel(m_ir) == 1) m_id = IDV;
        if (old == 4 && m_sel(m_ir) == 2) m_byp = d;
        if (old == 4 && m_sel(m_ir) == 1) m_id = (m_id >> 1) | (32'(d) << 31);
        if (old == 15) m_ir = m_irs;
        if (m_state == 0) m_ir = M_RST_IR;
    endtask

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One TCK cycle. Called just after a falling edge; returns just after the
    // next falling edge.
    task automatic step(input logic t, input logic d);
        logic exp_tdo;
        tms = t;
        tdi = d;
        bsr = 1'($urandom);
        model_edge(t, d);
        @(posedge tck);
        #1;
        check("state", 32'(state), 32'(m_state));
        check("clockDR", 32'(clock_dr),
              32'(m_sel(m_ir) == 0 && (m_state == 3 || m_state == 4)));
        check("shiftDR", 32'(shift_dr), 32'(m_state == 4));
        check("updateDR", 32'(update_dr), 32'(m_sel(m_ir) == 0 && m_state == 8));
        check("mode", 32'(mode), 32'(m_ir == 4'd0));
        @(negedge tck);
        #1;
        exp_tdo = 1'b0;
        if (m_state == 11) exp_tdo = m_irs[0];
        if (m_state == 4) begin
            case (m_sel(m_ir))
                0:       exp_tdo = bsr;
                1:       exp_tdo = m_id[0];
                default: exp_tdo = m_byp;
            endcase
        end
        check("tdo", 32'(tdo), 32'(exp_tdo));
        check("tdo_en", 32'(tdo_en), 32'(m_state == 4 || m_state == 11));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_state"}, 32'(state), 32'd0);
        check({tag, "_tdo"}, 32'(tdo), 32'd0);
        check({tag, "_tdo_en"}, 32'(tdo_en), 32'd0);
        check({tag, "_clockDR"}, 32'(clock_dr), 32'd0);
        check({tag, "_shiftDR"}, 32'(shift_dr), 32'd0);
        check({tag, "_updateDR"}, 32'(update_dr), 32'd0);
        check({tag, "_mode"}, 32'(mode), 32'd0);
    endtask

    // Asynchronous reset pulse between edges. Entered just after a falling
    // edge; leaves trst low before the next rising edge.
    task automatic pulse_reset(input string tag);
        #1 trst = 1'b1;
        #1 check_reset_outputs(tag);
        #1 trst = 1'b0;
        model_reset();
    endtask

    task automatic goto_tlr();
        for (int i = 0; i < 5; i++) step(1'b1, 1'($urandom));
        check("tlr5_state", 32'(state), 32'd0);
    endtask

    // Full scan starting from RTI, ending in RTI. Optionally pauses for three
    // cycles after shifting bit pause_at. cap collects TDO, LSB first.
    task automatic scan(input bit is_ir, input int n, input logic [63:0] data,
                        input int pause_at, output logic [63:0] cap);
        cap = '0;
        step(1'b1, 1'b0);
        if (is_ir) step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        cap[0] = tdo;
        for (int k = 0; k < n; k++) begin
            step((k == n - 1) || (k == pause_at), data[k]);
            if (k == pause_at && k != n - 1) begin
                step(1'b0, 1'b0);
                step(1'b0, 1'b0);
                step(1'b0, 1'b0);
                step(1'b1, 1'b0);
                step(1'b0, 1'b0);
            end
            if (k < n - 1) cap[k + 1] = tdo;
        end
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
    endtask

    logic [63:0] cap;

    initial begin
        n_cmp = 0;
        n_err = 0;
        trst  = 1'b1;
        tms   = 1'b1;
        tdi   = 1'b0;
        bsr   = 1'b0;
        model_reset();
        #3;
        check_reset_outputs("por");
        #8 trst = 1'b0;

        // wander somewhere, then five TMS=1 must land in TLR
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        goto_tlr();
        step(1'b0, 1'b0);

`ifdef TAP_IDCODE_EN
        scan(1'b0, 32, 64'h0, -1, cap);
        check("idcode_scan", cap[31:0], IDV);
`endif

        // IR scan of BYPASS with a pause after bit 1; capture must read 0001
        scan(1'b1, 4, 64'hF, 1, cap);
        check("ir_cap_b0", 32'(cap[0]), 32'd1);
        check("ir_cap_b1", 32'(cap[1]), 32'd0);
        check("ir_cap", 32'(cap[3:0]), 32'h1);

        // BYPASS DR scan: captured 0 then data delayed one bit
        scan(1'b0, 9, 64'h0A5, -1, cap);
        check("bypass_scan", 32'(cap[8:0]), 32'h14A);

        // EXTEST
        scan(1'b1, 4, 64'h0, -1, cap);
        check("mode_extest", 32'(mode), 32'd1);
        scan(1'b0, 12, 64'($urandom), 5, cap);

        // IDCODE opcode (BYPASS when the IDCODE register is absent)
        scan(1'b1, 4, 64'h2, 2, cap);
        scan(1'b0, 32, 64'($urandom), 10, cap);
        check("idop_scan_b0", 32'(cap[0]), 32'(M_HAS_ID));

        // SAMPLE/PRELOAD, then reset in the middle of the DR shift
        scan(1'b1, 4, 64'h1, -1, cap);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        pulse_reset("rst_mid_shdr");
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);

        // randomized phase
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                pulse_reset("rst_rand");
            end else if ($urandom_range(0, 99) == 0) begin
                goto_tlr();
            end else begin
                step(($urandom_range(0, 3) == 0), 1'($urandom));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
